// File: rtl/keypad_scanner_pkg.sv
// -----------------------------------------------------------------------------
// keypad_scanner_pkg
//  Shared constants, debounce state encoding and the 4x3 keypad key map used
//  by the keypad scanner and its debounce sub-block. NOKEY is the same idle
//  code consumed downstream by the alarm controller.
//
//  Contents
//   NUM_ROWS / NUM_COLS   keypad matrix geometry (4 rows x 3 columns)
//   NOKEY / KEY_STAR / KEY_HASH   special key codes (10 / 11 / 12)
//   deb_state_t           debounce FSM state encoding
//   key_map()             (row, col) -> 4-bit key code
// -----------------------------------------------------------------------------
package keypad_scanner_pkg;

    localparam int NUM_ROWS = 4;
    localparam int NUM_COLS = 3;

    localparam logic [3:0] NOKEY    = 4'd10;
    localparam logic [3:0] KEY_STAR = 4'd11;
    localparam logic [3:0] KEY_HASH = 4'd12;

    typedef enum logic [1:0] {
        ST_IDLE       = 2'd0,
        ST_PRESS_PEND = 2'd1,
        ST_HELD       = 2'd2,
        ST_REL_PEND   = 2'd3
    } deb_state_t;

    // Rows 0..2 carry the digits 1..9 in reading order; row 3 is * 0 #.
    function automatic logic [3:0] key_map(input logic [1:0] row, input logic [1:0] col);
        logic [3:0] code;
        if (row == 2'd3) begin
            case (col)
                2'd0:    code = KEY_STAR;
                2'd1:    code = 4'd0;
                default: code = KEY_HASH;
            endcase
        end else begin
            code = ({2'b00, row} * 4'd3) + {2'b00, col} + 4'd1;
        end
        return code;
    endfunction

endpackage

// File: rtl/keypad_scanner_key_debounce.sv
// -----------------------------------------------------------------------------
// keypad_scanner_key_debounce
//  Frame-rate debounce for the keypad scanner. Evaluated only on frame_end;
//  a press or a release is committed after DEBOUNCE_FRAMES identical frames.
//  The committed key never jumps from one pressed code to another: it always
//  passes through NOKEY first.
//
//  Ports
//   clk         in   system clock
//   reset       in   asynchronous, active-low
//   frame_end   in   one-cycle pulse marking the end of a scan frame
//   frame_code  in   [3:0] decoded code of the finished frame (NOKEY if none/multi)
//   key         out  [3:0] debounced key code, NOKEY when idle
//   key_strobe  out  one-cycle pulse when key takes a new pressed code
// -----------------------------------------------------------------------------
module keypad_scanner_key_debounce
    import keypad_scanner_pkg::*;
#(
    parameter int DEBOUNCE_FRAMES = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       frame_end,
    input  logic [3:0] frame_code,
    output logic [3:0] key,
    output logic       key_strobe
);

    localparam int CNT_W = $clog2(DEBOUNCE_FRAMES + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_FRAMES);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    deb_state_t       state_reg, state_next;
    logic [3:0]       cand_reg, cand_next;
    logic [CNT_W-1:0] cnt_reg, cnt_next;
    logic [CNT_W-1:0] cnt_inc;
    logic [3:0]       key_reg, key_next;
    logic             strobe_reg, strobe_next;

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg  <= ST_IDLE;
            cand_reg   <= NOKEY;
            cnt_reg    <= '0;
            key_reg    <= NOKEY;
            strobe_reg <= 1'b0;
        end else begin
            state_reg  <= state_next;
            cand_reg   <= cand_next;
            cnt_reg    <= cnt_next;
            key_reg    <= key_next;
            strobe_reg <= strobe_next;
        end
    end

    // Next-state logic. Strobe defaults low so it is a single-cycle pulse.
    always_comb begin
        state_next  = state_reg;
        cand_next   = cand_reg;
        cnt_next    = cnt_reg;
        key_next    = key_reg;
        strobe_next = 1'b0;
        cnt_inc     = cnt_reg + CNT_ONE;

        if (frame_end) begin
            case (state_reg)
                ST_IDLE: begin
                    if (frame_code != NOKEY) begin
                        cand_next = frame_code;
                        cnt_next  = CNT_ONE;
                        if (DEBOUNCE_FRAMES == 1) begin
                            key_next    = frame_code;
                            strobe_next = 1'b1;
                            cnt_next    = '0;
                            state_next  = ST_HELD;
                        end else begin
                            state_next = ST_PRESS_PEND;
                        end
                    end
                end

                ST_PRESS_PEND: begin
                    if (frame_code == cand_reg) begin
                        cnt_next = cnt_inc;
                        if (cnt_inc == CNT_MAX) begin
                            key_next    = cand_reg;
                            strobe_next = 1'b1;
                            cnt_next    = '0;
                            state_next  = ST_HELD;
                        end
                    end else if (frame_code != NOKEY) begin
                        // A different key restarts the candidate count.
                        cand_next = frame_code;
                        cnt_next  = CNT_ONE;
                    end else begin
                        cnt_next   = '0;
                        state_next = ST_IDLE;
                    end
                end

                ST_HELD: begin
                    if (frame_code != key_reg) begin
                        cnt_next = CNT_ONE;
                        if (DEBOUNCE_FRAMES == 1) begin
                            key_next   = NOKEY;
                            cnt_next   = '0;
                            state_next = ST_IDLE;
                        end else begin
                            state_next = ST_REL_PEND;
                        end
                    end
                end

                ST_REL_PEND: begin
                    if (frame_code == key_reg) begin
                        // Short open-frame glitch: keep the held key.
                        cnt_next   = '0;
                        state_next = ST_HELD;
                    end else begin
                        // Any other code (including another key) counts as
                        // release; a new key is debounced only from IDLE.
                        cnt_next = cnt_inc;
                        if (cnt_inc == CNT_MAX) begin
                            key_next   = NOKEY;
                            cnt_next   = '0;
                            state_next = ST_IDLE;
                        end
                    end
                end

                default: begin
                    cnt_next   = '0;
                    state_next = ST_IDLE;
                end
            endcase
        end
    end

    // Outputs come straight from registers.
    always_comb begin
        key        = key_reg;
        key_strobe = strobe_reg;
    end

endmodule

// File: rtl/keypad_scanner.sv
// -----------------------------------------------------------------------------
// keypad_scanner
//  Scans a 4x3 active-low matrix keypad. An active-low strobe rotates across
//  the columns, the row returns are synchronised with two flops, and the hits
//  of each column are merged into one decoded code per scan frame. The code is
//  then debounced across frames before it appears on key.
//
//  Ports
//   clk         in   system clock (256 Hz)
//   reset       in   asynchronous, active-low; clears all state
//   row_n       in   [3:0] keypad rows, active-low, asynchronous to clk
//   col_n       out  [2:0] column strobes, one-hot-low
//   key         out  [3:0] debounced key code, NOKEY when idle
//   key_strobe  out  one-cycle pulse when key takes a new pressed code
//   multi_key   out  one-cycle pulse at the end of a frame with >1 key pressed
// -----------------------------------------------------------------------------
module keypad_scanner
    import keypad_scanner_pkg::*;
#(
    parameter int COL_DWELL       = 3,
    parameter int DEBOUNCE_FRAMES = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] row_n,
    output logic [2:0] col_n,
    output logic [3:0] key,
    output logic       key_strobe,
    output logic       multi_key
);

    localparam int DWELL_W = $clog2(COL_DWELL);
    localparam logic [DWELL_W-1:0] DWELL_LAST = DWELL_W'(COL_DWELL - 1);
    localparam logic [1:0]         COL_LAST   = 2'(NUM_COLS - 1);

    // ------------------------------------------------------------------
    // Row synchroniser (rows idle high)
    // ------------------------------------------------------------------
    logic [NUM_ROWS-1:0] row_meta_reg;
    logic [NUM_ROWS-1:0] row_sync_reg;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            row_meta_reg <= '1;
            row_sync_reg <= '1;
        end else begin
            row_meta_reg <= row_n;
            row_sync_reg <= row_meta_reg;
        end
    end

    // ------------------------------------------------------------------
    // Column rotator / dwell counter. Rows are sampled on the last dwell
    // cycle; with a dwell of at least 3 the two synchroniser stages have
    // already flushed the previous column's returns by then.
    // ------------------------------------------------------------------
    logic [DWELL_W-1:0] dwell_reg;
    logic [1:0]         col_reg;
    logic               sample_en;
    logic               frame_end;

    assign sample_en = (dwell_reg == DWELL_LAST);
    assign frame_end = sample_en && (col_reg == COL_LAST);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            dwell_reg <= '0;
            col_reg   <= '0;
        end else if (sample_en) begin
            dwell_reg <= '0;
            col_reg   <= (col_reg == COL_LAST) ? 2'd0 : col_reg + 2'd1;
        end else begin
            dwell_reg <= dwell_reg + DWELL_W'(1);
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < NUM_COLS; gi++) begin : g_col
            assign col_n[gi] = (col_reg != 2'(gi));
        end
    endgenerate

    // ------------------------------------------------------------------
    // Per-column decode
    // ------------------------------------------------------------------
    logic [NUM_ROWS-1:0] row_hit;

    generate
        for (gi = 0; gi < NUM_ROWS; gi++) begin : g_row
            assign row_hit[gi] = ~row_sync_reg[gi];
        end
    endgenerate

    logic [2:0] col_hits;
    logic [1:0] col_row;
    logic [3:0] col_code;

    always_comb begin
        col_hits = 3'd0;
        col_row  = 2'd0;
        for (int r = 0; r < NUM_ROWS; r++) begin
            if (row_hit[r]) begin
                col_hits = col_hits + 3'd1;
                col_row  = 2'(r);
            end
        end
    end

    assign col_code = key_map(col_row, col_reg);

    // ------------------------------------------------------------------
    // Frame accumulator. Hit count saturates at 2: only "none", "exactly
    // one" and "more than one" matter. The current column's hits are
    // merged combinationally so the frame result is ready on its last
    // sample.
    // ------------------------------------------------------------------
    logic [1:0] acc_hits_reg;
    logic [3:0] acc_code_reg;
    logic [2:0] hits_sum;
    logic [1:0] merged_hits;
    logic [3:0] merged_code;
    logic [3:0] frame_code;
    logic       frame_multi;
    logic       multi_reg;

    always_comb begin
        hits_sum    = {1'b0, acc_hits_reg} + col_hits;
        merged_hits = (hits_sum >= 3'd2) ? 2'd2 : hits_sum[1:0];
        merged_code = (col_hits == 3'd1) ? col_code : acc_code_reg;
        frame_code  = (merged_hits == 2'd1) ? merged_code : NOKEY;
        frame_multi = (merged_hits == 2'd2);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            acc_hits_reg <= 2'd0;
            acc_code_reg <= NOKEY;
            multi_reg    <= 1'b0;
        end else begin
            multi_reg <= frame_end && frame_multi;
            if (sample_en) begin
                if (frame_end) begin
                    acc_hits_reg <= 2'd0;
                    acc_code_reg <= NOKEY;
                end else begin
                    acc_hits_reg <= merged_hits;
                    acc_code_reg <= merged_code;
                end
            end
        end
    end

    assign multi_key = multi_reg;

    // ------------------------------------------------------------------
    // Debounce
    // ------------------------------------------------------------------
    keypad_scanner_key_debounce #(
        .DEBOUNCE_FRAMES (DEBOUNCE_FRAMES)
    ) u_debounce (
        .clk        (clk),
        .reset      (reset),
        .frame_end  (frame_end),
        .frame_code (frame_code),
        .key        (key),
        .key_strobe (key_strobe)
    );

endmodule
